// File: rtl/boru_hatli_toplayici_pkg.sv
// Shared constants, stage-count helper and the per-stage pipeline record
// for the pipelined adder/subtractor.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro: ADDER_OVF_EN adds a registered signed-overflow bit.
package toplayici_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;
  // Record fields are sized for the widest supported operand so the type can
  // live in the package; a module instance uses only the low WIDTH bits.
  localparam int MAX_WIDTH = 64;

  function automatic int stages_of(input int width, input int seg);
    return width / seg;
  endfunction

  // One pipeline stage: finished result segments, the operand segments not
  // yet consumed (right-aligned so the next segment is always bits [SEG-1:0]),
  // and the carry handed to the following stage.
  typedef struct packed {
    logic                 vld;
    logic                 carry;
`ifdef ADDER_OVF_EN
    logic                 ovf;
`endif
    logic [MAX_WIDTH-1:0] psum;
    logic [MAX_WIDTH-1:0] rem_a;
    logic [MAX_WIDTH-1:0] rem_b;
  } stage_rec_t;

endpackage

// File: rtl/boru_hatli_toplayici_segment.sv
// Combinational SEG-bit ripple-carry adder slice used by every pipeline stage.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: a_i/b_i operands, c_i carry-in; s_o sum, c_o carry-out,
//        msb_c_o carry into the top bit (signed overflow = msb_c_o ^ c_o).
module segment_toplayici #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] s_o,
  output logic           c_o,
  output logic           msb_c_o
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < SEG; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c[SEG];
  assign msb_c_o = c[SEG-1];

endmodule

// File: rtl/boru_hatli_toplayici.sv
// Pipelined two's-complement adder/subtractor, one SEG-bit segment per stage.
// Latency: result valid after edge n+STAGES-1 for a transaction accepted on edge n.
// Backpressure: whole pipeline freezes (bubbles kept) while out_valid && !out_ready;
//               in_ready = !out_valid || out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/sub operand side;
//        out_valid/out_ready/sum/carry_out result side; ovf only with ADDER_OVF_EN.
module boru_hatli_toplayici
  import toplayici_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages_of(WIDTH, SEG);

  if ((WIDTH % SEG) != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of SEG");
  end
  if (WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("WIDTH exceeds the package record width");
  end

  stage_rec_t stg_q [STAGES];
  stage_rec_t stg_d [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  logic [SEG-1:0] seg_a      [STAGES];
  logic [SEG-1:0] seg_b      [STAGES];
  logic           seg_ci     [STAGES];
  logic [SEG-1:0] seg_s      [STAGES];
  logic           seg_co     [STAGES];
  logic           seg_msb_ci [STAGES];

  // Single global enable: every stage moves together, so a stall never
  // reorders or squeezes out bubbles.
  assign adv      = !stg_q[STAGES-1].vld || out_ready;
  assign in_ready = adv;

  // Subtract as A + ~B + 1: invert B on entry, inject sub as stage-0 carry.
  assign b_eff = b ^ {WIDTH{sub}};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign seg_a[g]  = a[SEG-1:0];
      assign seg_b[g]  = b_eff[SEG-1:0];
      assign seg_ci[g] = sub;
    end else begin : g_rest
      assign seg_a[g]  = stg_q[g-1].rem_a[SEG-1:0];
      assign seg_b[g]  = stg_q[g-1].rem_b[SEG-1:0];
      assign seg_ci[g] = stg_q[g-1].carry;
    end

    segment_toplayici #(.SEG(SEG)) u_seg (
      .a_i     (seg_a[g]),
      .b_i     (seg_b[g]),
      .c_i     (seg_ci[g]),
      .s_o     (seg_s[g]),
      .c_o     (seg_co[g]),
      .msb_c_o (seg_msb_ci[g])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k] = '0;
    end

    stg_d[0].vld   = in_valid;
    stg_d[0].carry = seg_co[0];
    stg_d[0].psum  = MAX_WIDTH'(seg_s[0]);
    stg_d[0].rem_a = MAX_WIDTH'(a) >> SEG;
    stg_d[0].rem_b = MAX_WIDTH'(b_eff) >> SEG;

    for (int k = 1; k < STAGES; k++) begin
      stg_d[k].vld   = stg_q[k-1].vld;
      stg_d[k].carry = seg_co[k];
      stg_d[k].psum  = stg_q[k-1].psum | (MAX_WIDTH'(seg_s[k]) << (k * SEG));
      stg_d[k].rem_a = stg_q[k-1].rem_a >> SEG;
      stg_d[k].rem_b = stg_q[k-1].rem_b >> SEG;
    end

`ifdef ADDER_OVF_EN
    // Only the stage holding the MSB segment can see the sign-bit carries.
    stg_d[STAGES-1].ovf = seg_msb_ci[STAGES-1] ^ seg_co[STAGES-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign out_valid = stg_q[STAGES-1].vld;
  assign sum       = stg_q[STAGES-1].psum[WIDTH-1:0];
  assign carry_out = stg_q[STAGES-1].carry;
`ifdef ADDER_OVF_EN
  assign ovf       = stg_q[STAGES-1].ovf;
`endif

  // Record bits beyond the live segments (and the sign-carry tap when ovf is
  // not built) are intentionally left unread; gather them here.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_bits = unused_bits ^ (^stg_q[k]) ^ seg_msb_ci[k];
    end
  end

endmodule

// File: tb/tb_boru_hatli_toplayici.sv
module tb_boru_hatli_toplayici;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  boru_hatli_toplayici #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
    res_t r;
    int unsigned ua = xa;
    int unsigned ub = xb;
    int sa = $signed(xa);
    int sb = $signed(xb);
    int sr;
    if (!xs) begin
      r.s = W'(ua + ub);
      r.c = (ua + ub) > 32'hFFFF;
      sr  = sa + sb;
    end else begin
      r.s = W'(ua - ub);
      r.c = ua >= ub;
      sr  = sa - sb;
    end
    r.o = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  // Scoreboard, observed at the falling edge (transfers happen on the next rise).
  res_t exp_q [$];
  int   acc_q [$];
  int   cyc     = 0;
  int   n_in    = 0;
  int   n_out   = 0;
  bit   chk_lat = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      cyc++;
      if (out_valid && out_ready) begin
        chk("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          res_t e;
          int   t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          chk("sb_sum", 32'(sum), 32'(e.s));
          chk("sb_carry", 32'(carry_out), 32'(e.c));
`ifdef ADDER_OVF_EN
          chk("sb_ovf", 32'(ovf), 32'(e.o));
`endif
          if (chk_lat) chk("sb_latency", 32'(cyc - t), 32'd4);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        acc_q.push_back(cyc);
        n_in++;
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs [7];

  task automatic drain(input string nm);
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra [8];
    logic [W-1:0] rb [8];
    logic         rs [8];
    logic [W:0]   hold;
    int           i;
    int           c;
    int           edges;
    int           base_in;
    int           base_out;
    int           seen;
    bit           acc;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one at a time, with latency measurement.
    chk_lat = 1'b1;
    for (int v = 0; v < 7; v++) begin
      a = vecs[v].a; b = vecs[v].b; sub = vecs[v].sub; in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 20) begin
        @(posedge clk); #1;
        edges++;
      end
      chk($sformatf("vec%0d_latency", v), 32'(edges), 32'd4);
      chk($sformatf("vec%0d_sum", v), 32'(sum), 32'(vecs[v].s));
      chk($sformatf("vec%0d_carry", v), 32'(carry_out), 32'(vecs[v].c));
`ifdef ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].o));
`endif
      @(posedge clk); #1;
    end
    chk_lat = 1'b0;

    // Back-to-back burst with a 3-cycle consumer stall in the middle.
    for (int k = 0; k < 8; k++) begin
      ra[k] = W'($urandom()); rb[k] = W'($urandom()); rs[k] = 1'($urandom());
    end
    base_out = n_out;
    i = 0; c = 0; hold = '0;
    while (i < 8 && c < 60) begin
      in_valid = 1'b1; a = ra[i]; b = rb[i]; sub = rs[i];
      out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      if (c >= 5 && c <= 7) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (c == 5) hold = {carry_out, sum};
        else chk("stall_hold", 32'({carry_out, sum}), 32'(hold));
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    chk("bp_all_sent", 32'(i), 32'd8);
    drain("bp_drain");
    chk("bp_all_out", 32'(n_out - base_out), 32'd8);

    // Bubbles: valid every other cycle, results must keep identical spacing.
    chk_lat  = 1'b1;
    base_in  = n_in;
    base_out = n_out;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k % 2 == 0);
      a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    drain("bub_drain");
    chk_lat = 1'b0;
    chk("bub_in_count", 32'(n_in - base_in), 32'd10);
    chk("bub_out_count", 32'(n_out - base_out), 32'd10);

    // Random valid/ready traffic; producer holds operands until accepted.
    i = 0; c = 0;
    a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
    while (i < 40 && c < 2000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
      end
      c++;
    end
    chk("rand_all_sent", 32'(i), 32'd40);
    drain("rand_drain");

    // Reset while transactions are in flight: nothing may emerge afterwards.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_carry", 32'(carry_out), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post_rst_no_stale", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
